// File: rtl/logic_gate_pkg.sv
// Shared types and the per-bit gate function for the pipelined logic unit.
package logic_gate_pkg;

    localparam int unsigned GATE_OP_W = 3;

    typedef enum logic [GATE_OP_W-1:0] {
        GATE_AND   = 3'd0,
        GATE_OR    = 3'd1,
        GATE_NAND  = 3'd2,
        GATE_NOR   = 3'd3,
        GATE_XOR   = 3'd4,
        GATE_XNOR  = 3'd5,
        GATE_NOT_A = 3'd6,
        GATE_BUF_A = 3'd7
    } gate_op_t;

    // Single-bit gate; callers apply it across their own datapath width.
    function automatic logic gate_eval(input gate_op_t op, input logic a, input logic b);
        logic y;
        y = 1'b0;
        case (op)
            GATE_AND:   y = a & b;
            GATE_OR:    y = a | b;
            GATE_NAND:  y = ~(a & b);
            GATE_NOR:   y = ~(a | b);
            GATE_XOR:   y = a ^ b;
            GATE_XNOR:  y = ~(a ^ b);
            GATE_NOT_A: y = ~a;
            GATE_BUF_A: y = a;
            default:    y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One pipeline slot: valid bit plus data word, loaded only when the pipe advances.
module logic_gate_stage
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Next state: take the upstream slot on advance, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    // Slot register, cleared asynchronously so in-flight data vanishes at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined WIDTH-bit logic unit with run-time gate select and valid/ready on both sides.
// Optional transfer counter out_count is built only when GATE_STATS_EN is defined.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GATE_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_y
`ifdef GATE_STATS_EN
    ,
    output logic [CNT_W-1:0]     out_count
`endif
);

    if (WIDTH < 1 || STAGES < 1 || CNT_W < 1) begin : g_bad_params
        $error("logic_gate_pipe: WIDTH, STAGES and CNT_W must all be >= 1");
    end

    logic             adv_c;
    logic [WIDTH-1:0] result_c;
    logic [STAGES:0]  stg_valid;
    logic [WIDTH-1:0] stg_data [STAGES+1];

    // Whole pipe moves together whenever the output slot is empty or being drained.
    assign adv_c    = !out_valid || out_ready;
    assign in_ready = adv_c;

    // Gate function evaluated on the accept cycle, bit by bit.
    always_comb begin
        result_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result_c[i] = gate_eval(gate_op_t'(in_op), in_a[i], in_b[i]);
        end
    end

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = result_c;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic_gate_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv_c),
            .valid_i (stg_valid[s]),
            .data_i  (stg_data[s]),
            .valid_o (stg_valid[s+1]),
            .data_o  (stg_data[s+1])
        );
    end

    assign out_valid = stg_valid[STAGES];
    assign out_y     = stg_data[STAGES];

`ifdef GATE_STATS_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Count completed output handshakes, wrapping naturally at 2^CNT_W.
    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed-plus-random bench for logic_gate_pipe (WIDTH=8, STAGES=2) with a queue scoreboard.
module tb_logic_gate_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;
    localparam int unsigned CNT_W  = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
`ifdef GATE_STATS_EN
    logic [CNT_W-1:0] out_count;
`endif

    int               total;
    int               bad;
    int               out_xfers;
    logic [WIDTH-1:0] exp_q [$];
    logic             stall_prev;
    logic [WIDTH-1:0] y_prev;

    logic_gate_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
`ifdef GATE_STATS_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate from the op table, whole-word arithmetic.
    function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_in(input logic v);
        in_valid = v;
        in_op    = 3'($urandom_range(0, 7));
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
    endtask

    // One clock: sample handshakes on the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", 32'(out_y), 32'(y_prev));
        end
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            out_xfers++;
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else check("out_data", 32'(out_y), 32'(exp_q.pop_front()));
        end
        if (in_valid && in_ready) exp_q.push_back(ref_gate(in_op, in_a, in_b));
        stall_prev = out_valid && !out_ready;
        y_prev     = out_y;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] tbl [8];
        tbl        = '{8'h03, 8'h3F, 8'hFC, 8'hC0, 8'h3C, 8'hC3, 8'hF0, 8'h0F};
        total      = 0;
        bad        = 0;
        out_xfers  = 0;
        stall_prev = 1'b0;
        y_prev     = '0;

        // Reset held with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_in(1'($urandom));
            out_ready = 1'($urandom);
            @(negedge clk);
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_y", 32'(out_y), 32'd0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single NAND, latency of two cycles
        in_valid = 1'b1; in_op = 3'd2; in_a = 8'h0F; in_b = 8'h33;
        tick();
        in_valid = 1'b0;
        check("nand_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check("nand_valid", 32'(out_valid), 32'd1);
        check("nand_y", 32'(out_y), 32'h0000_00FC);
        tick();
        check("nand_after", 32'(out_valid), 32'd0);

        // All eight ops back-to-back
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; in_op = 3'(k); in_a = 8'h0F; in_b = 8'h33;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k >= 1 && k <= 8) begin
                check("allop_valid", 32'(out_valid), 32'd1);
                check("allop_y", 32'(out_y), 32'(tbl[k-1]));
            end
        end
        drain();

        // Backpressure: fill, stall three cycles, release
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_in(1'b1);
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_in(1'b1);
            tick();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_in(1'b1);
            tick();
        end
        drain();

        // Random traffic with bubbles and stalls
        for (int i = 0; i < 200; i++) begin
            rand_in(1'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Asynchronous reset with two transfers in flight
        out_ready = 1'b1;
        rand_in(1'b1);
        tick();
        rand_in(1'b1);
        tick();
        in_valid = 1'b0;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(out_y), 32'd0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef GATE_STATS_EN
        // Transfer counter wraps modulo 2^CNT_W
        begin
            int n;
            #1;
            rst = 1'b1;
            #1;
            rst = 1'b0;
            exp_q.delete();
            stall_prev = 1'b0;
            check("stats_rst", 32'(out_count), 32'd0);
            out_xfers = 0;
            out_ready = 1'b1;
            n = 0;
            while (out_xfers < 300 && n < 400) begin
                rand_in(1'b1);
                tick();
                n++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("stats_xfers", 32'(out_xfers), 32'd300);
            check("stats_count", 32'(out_count), 32'(300 % 256));
            drain();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
